// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory fetch unit.
// IMEM_PARITY_EN adds one even-parity bit per stored word.
package imem_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, LOAD} imem_state_e;

  localparam int PAR_MAX_W = 64;
  localparam logic [PAR_MAX_W-1:0] NOP_INSTR = '0;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic parity_f(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Program store with synchronous write and registered synchronous read.
// IMEM_PARITY_EN: stores/checks a parity bit per word and adds inj_par_err.
module imem_array
  import imem_pkg::*;
#(
  parameter int INSTR_WIDTH = 8,
  parameter int IMEM_DEPTH  = 16,
  parameter int ADDR_WIDTH  = $clog2(IMEM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   we,
  input  logic [ADDR_WIDTH-1:0]  waddr,
  input  logic [INSTR_WIDTH-1:0] wdata,
`ifdef IMEM_PARITY_EN
  input  logic                   inj_par_err,
`endif
  input  logic                   re,
  input  logic [ADDR_WIDTH-1:0]  raddr,
  output logic [INSTR_WIDTH-1:0] rdata,
  output logic                   rerr
);

`ifdef IMEM_PARITY_EN
  localparam int WORD_W = INSTR_WIDTH + 1;
`else
  localparam int WORD_W = INSTR_WIDTH;
`endif
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(IMEM_DEPTH);

  logic [WORD_W-1:0] mem [IMEM_DEPTH];
  logic [WORD_W-1:0] wword, rword;
  logic              wr_ok, rd_ok, bad;

  // Depth need not be a power of two, so both ports range-check.
  assign wr_ok = {1'b0, waddr} < DEPTH_W;
  assign rd_ok = {1'b0, raddr} < DEPTH_W;
  assign rword = mem[raddr];

`ifdef IMEM_PARITY_EN
  assign wword = {parity_f(PAR_MAX_W'(wdata)) ^ inj_par_err, wdata};
  assign bad   = !rd_ok ||
                 (parity_f(PAR_MAX_W'(rword[INSTR_WIDTH-1:0])) != rword[INSTR_WIDTH]);
`else
  assign wword = wdata;
  assign bad   = !rd_ok;
`endif

  // Contents deliberately survive reset.
  always_ff @(posedge clk)
    if (we && wr_ok) mem[waddr] <= wword;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
      rerr  <= 1'b0;
    end else if (re) begin
      rerr  <= bad;
      rdata <= bad ? INSTR_WIDTH'(NOP_INSTR) : rword[INSTR_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction fetch unit: valid/ready fetch port, one-entry response, loader port.
// IMEM_PARITY_EN enables per-word parity and the inj_par_err test input.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter  int INSTR_WIDTH = 8,
  parameter  int IMEM_DEPTH  = 16,
  localparam int ADDR_WIDTH  = $clog2(IMEM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   ld_en,
  input  logic                   ld_we,
  input  logic [ADDR_WIDTH-1:0]  ld_addr,
  input  logic [INSTR_WIDTH-1:0] ld_data,
`ifdef IMEM_PARITY_EN
  input  logic                   inj_par_err,
`endif
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [INSTR_WIDTH-1:0] rsp_instr,
  output logic [ADDR_WIDTH-1:0]  rsp_addr,
  output logic                   rsp_err
);

  imem_state_e state;
  logic        accept, ld_wr;

  // A held response blocks new requests until consumed; the loader always blocks.
  always_comb begin
    req_ready = 1'b0;
    case (state)
      IDLE:    req_ready = !ld_en;
      HOLD:    req_ready = rsp_ready && !ld_en;
      default: req_ready = 1'b0;
    endcase
    if (!reset_n) req_ready = 1'b0;
  end

  assign accept = req_valid && req_ready;
  assign ld_wr  = (state == LOAD) && ld_we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
    end else begin
      case (state)
        IDLE:
          if (ld_en) state <= LOAD;
          else if (req_valid) begin
            state     <= HOLD;
            rsp_valid <= 1'b1;
            rsp_addr  <= req_addr;
          end
        HOLD:
          if (rsp_ready) begin
            if (ld_en) begin
              state     <= LOAD;
              rsp_valid <= 1'b0;
            end else if (req_valid) begin
              rsp_addr  <= req_addr;
            end else begin
              state     <= IDLE;
              rsp_valid <= 1'b0;
            end
          end
        LOAD:
          if (!ld_en) state <= IDLE;
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  imem_array #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .IMEM_DEPTH  (IMEM_DEPTH),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_array (
    .clk         (clk),
    .reset_n     (reset_n),
    .we          (ld_wr),
    .waddr       (ld_addr),
    .wdata       (ld_data),
`ifdef IMEM_PARITY_EN
    .inj_par_err (inj_par_err),
`endif
    .re          (accept),
    .raddr       (req_addr),
    .rdata       (rsp_instr),
    .rerr        (rsp_err)
  );

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed scoreboard bench for imem_fetch_unit (IMEM_DEPTH=10 to exercise out-of-range).
module tb_imem_fetch_unit;

  localparam int IW = 8;
  localparam int D  = 10;
  localparam int AW = 4;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          ld_en = 1'b0, ld_we = 1'b0, req_valid = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] ld_addr = '0, req_addr = '0;
  logic [IW-1:0] ld_data = '0;
`ifdef IMEM_PARITY_EN
  logic          inj_par_err = 1'b0;
`endif
  logic          req_ready, rsp_valid, rsp_err;
  logic [IW-1:0] rsp_instr;
  logic [AW-1:0] rsp_addr;

  imem_fetch_unit #(.INSTR_WIDTH(IW), .IMEM_DEPTH(D)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ld_en       (ld_en),
    .ld_we       (ld_we),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
`ifdef IMEM_PARITY_EN
    .inj_par_err (inj_par_err),
`endif
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_instr   (rsp_instr),
    .rsp_addr    (rsp_addr),
    .rsp_err     (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] instr;
    logic          err;
  } exp_t;

  exp_t          sbq[$];
  logic [AW-1:0] aq[$];
  logic [IW-1:0] model [16];
  logic          pbad  [16];
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [AW-1:0] a);
    exp_t e;
    e.addr = a;
    if (int'(a) >= D || pbad[a]) begin
      e.instr = '0;
      e.err   = 1'b1;
    end else begin
      e.instr = model[a];
      e.err   = 1'b0;
    end
    sbq.push_back(e);
  endtask

  task automatic chk_rsp(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_sb: observed empty scoreboard required one entry", tag);
      return;
    end
    e = sbq.pop_front();
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_instr"}, 32'(rsp_instr), 32'(e.instr));
    chk({tag, "_addr"},  32'(rsp_addr),  32'(e.addr));
    chk({tag, "_err"},   32'(rsp_err),   32'(e.err));
  endtask

  // One loader write cycle; the model mirrors what an in-range write should store.
  task automatic ld_word(input logic [AW-1:0] a, input logic [IW-1:0] d, input logic inj);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
`ifdef IMEM_PARITY_EN
    inj_par_err = inj;
`endif
    tick();
    if (int'(a) < D) begin
      model[a] = d;
      pbad[a]  = inj;
    end
    ld_we = 1'b0;
`ifdef IMEM_PARITY_EN
    inj_par_err = 1'b0;
`endif
  endtask

  // Back-to-back fetches of aq with rsp_ready held high; every cycle must carry a response.
  task automatic b2b(input string tag);
    rsp_ready = 1'b1;
    foreach (aq[i]) begin
      req_valid = 1'b1; req_addr = aq[i];
      @(negedge clk);
      chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
      if (i > 0) chk_rsp(tag);
      push_exp(aq[i]);
      tick();
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk_rsp(tag);
    tick();
    @(negedge clk);
    chk({tag, "_idle"}, 32'(rsp_valid), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      model[i] = '0;
      pbad[i]  = 1'b0;
    end

    // Reset state
    @(negedge clk);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_instr", 32'(rsp_instr), 32'd0);
    chk("rst_addr",  32'(rsp_addr),  32'd0);
    chk("rst_err",   32'(rsp_err),   32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    tick();
    reset_n = 1'b1;

    // Load program, including an ignored out-of-range write
    ld_en = 1'b1;
    tick();
    @(negedge clk);
    chk("load_ready", 32'(req_ready), 32'd0);
    chk("load_valid", 32'(rsp_valid), 32'd0);
    tick();
    ld_word(4'd0, 8'h11, 1'b0);
    ld_word(4'd1, 8'h22, 1'b0);
    ld_word(4'd2, 8'h33, 1'b0);
    ld_word(4'd3, 8'h44, 1'b0);
    ld_word(4'd9, 8'h99, 1'b0);
    ld_word(4'd12, 8'hFF, 1'b0);
    ld_en = 1'b0;
    tick();

    // Single fetch of addr 2, held one cycle before consumption
    req_valid = 1'b1; req_addr = 4'd2; rsp_ready = 1'b0;
    @(negedge clk);
    chk("f2_rdy", 32'(req_ready), 32'd1);
    push_exp(4'd2);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk_rsp("f2");
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("f2_idle", 32'(rsp_valid), 32'd0);
    tick();

    // Full-throughput stream
    aq = {4'd0, 4'd1, 4'd2, 4'd3};
    b2b("b2b");

    // Backpressure: response for addr 1 held while addr 3 waits
    req_valid = 1'b1; req_addr = 4'd1; rsp_ready = 1'b0;
    @(negedge clk);
    push_exp(4'd1);
    tick();
    req_addr = 4'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rdy",   32'(req_ready), 32'd0);
      chk("stall_instr", 32'(rsp_instr), 32'(sbq[0].instr));
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_rel_rdy", 32'(req_ready), 32'd1);
    chk_rsp("stall1");
    push_exp(4'd3);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk_rsp("stall3");
    tick();

    // Out-of-range then last valid word
    aq = {4'd12, 4'd9, 4'd15};
    b2b("oor");

    // Loader requested while a response is held: no write until the response drains
    req_valid = 1'b1; req_addr = 4'd0; rsp_ready = 1'b0;
    @(negedge clk);
    push_exp(4'd0);
    tick();
    req_valid = 1'b0;
    ld_en = 1'b1; ld_we = 1'b1; ld_addr = 4'd2; ld_data = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ldhold_valid", 32'(rsp_valid), 32'd1);
      chk("ldhold_rdy",   32'(req_ready), 32'd0);
      chk("ldhold_instr", 32'(rsp_instr), 32'(sbq[0].instr));
      tick();
    end
    ld_we = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk_rsp("ldhold");
    tick();
    @(negedge clk);
    chk("ld_valid", 32'(rsp_valid), 32'd0);
    chk("ld_rdy",   32'(req_ready), 32'd0);
    tick();
    ld_word(4'd1, 8'hA5, 1'b0);
    ld_en = 1'b0;
    tick();
    aq = {4'd1, 4'd2};
    b2b("reload");

    // Asynchronous reset while holding a response
    req_valid = 1'b1; req_addr = 4'd3; rsp_ready = 1'b0;
    @(negedge clk);
    push_exp(4'd3);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("prerst_valid", 32'(rsp_valid), 32'd1);
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(rsp_valid), 32'd0);
    chk("arst_rdy",   32'(req_ready), 32'd0);
    chk("arst_instr", 32'(rsp_instr), 32'd0);
    sbq.delete();
    tick();
    reset_n = 1'b1;
    tick();
    aq = {4'd0};
    b2b("retain");

`ifdef IMEM_PARITY_EN
    ld_en = 1'b1;
    tick();
    ld_word(4'd5, 8'h5C, 1'b1);
    ld_word(4'd6, 8'h66, 1'b0);
    ld_en = 1'b0;
    tick();
    aq = {4'd5, 4'd6};
    b2b("parity");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
Parametrised, clocked successor to the combinational instruction ROM. It holds an INSTR_WIDTH x IMEM_DEPTH program store that is writable through a loader port. Fetches use a valid/ready request/response handshake with 1-cycle synchronous read latency and a one-entry response buffer. It sits between the PC/fetch stage and decode, and can be reloaded at run time without re-elaborating.

Parameters:
INSTR_WIDTH, 8, bits per instruction word
IMEM_DEPTH, 16, number of words; any value >= 2, not necessarily a power of 2
ADDR_WIDTH, $clog2(IMEM_DEPTH), width of all address ports (derived localparam, not overridable)

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
ld_en  in  1  loader mode request; while high, fetch is blocked
ld_we  in  1  loader write strobe, honoured only in LOAD state
ld_addr  in  ADDR_WIDTH  loader write address
ld_data  in  INSTR_WIDTH  loader write data
req_valid  in  1  fetch request valid
req_ready  out  1  fetch request accepted this cycle when high together with req_valid
req_addr  in  ADDR_WIDTH  fetch address (PC)
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_instr  out  INSTR_WIDTH  fetched instruction
rsp_addr  out  ADDR_WIDTH  address the response belongs to
rsp_err  out  1  request address >= IMEM_DEPTH

Behaviour:
- Reset (async assert, sync deassert by the environment): state=IDLE; rsp_valid=0; rsp_instr=0; rsp_addr=0; rsp_err=0; req_ready=0 while reset_n=0. Memory contents are not cleared by reset.
- FSM states: IDLE (no response held), HOLD (response held), LOAD.
- IDLE:
  - ld_en=1 -> LOAD.
  - Else req_ready=1; on req_valid -> capture mem[req_addr] into rsp_instr next edge, rsp_valid=1 -> HOLD.
- HOLD:
  - rsp_valid=1; outputs stable until handshake.
  - req_ready = rsp_ready && !ld_en.
  - rsp_ready && req_valid && !ld_en -> back-to-back: new response next cycle, stay HOLD (full throughput, 1 word/cycle).
  - rsp_ready && !req_valid -> IDLE.
  - rsp_ready && ld_en -> LOAD.
  - !rsp_ready -> stay HOLD, even if ld_en=1; the pending response is never dropped.
- LOAD:
  - req_ready=0; rsp_valid=0.
  - ld_we writes ld_data to mem[ld_addr] at the edge.
  - ld_en=0 -> IDLE.
  - Writes with ld_addr >= IMEM_DEPTH are ignored.
- Latency: request accepted at edge N -> rsp_valid at edge N+1.
- Out-of-range: req_addr >= IMEM_DEPTH is accepted; the response has rsp_instr = 0 (NOP) and rsp_err = 1. rsp_err is cleared on the next in-range response.
- Loader priority: ld_en blocks new requests in the same cycle (req_ready low). A write and a read can never target the same word in the same cycle.
- Reset mid-operation: any held response is discarded immediately (rsp_valid -> 0 asynchronously); LOAD is abandoned and partially loaded words remain.

Optional Feature:
Macro IMEM_PARITY_EN.
- Defined: each word stores one extra even-parity bit computed on loader write. The parity is checked on read; a mismatch sets rsp_err=1 and forces rsp_instr=0. Adds an input port inj_par_err (1 bit) that flips the stored parity bit on the next loader write, for test.
- Undefined: no parity storage and no inj_par_err port; rsp_err reflects out-of-range only.

Decomposition:
- Package imem_pkg:
  - state enum typedef imem_state_e {IDLE, HOLD, LOAD};
  - localparam NOP_INSTR = '0 (sized per use);
  - function parity_f.
- One sub-module, imem_array: storage plus synchronous read/write, parity included under the macro. It carries no handshake logic.
- imem_fetch_unit holds the FSM and response register.

Test Plan:
- Load mem[0..3] = 8'h11, 8'h22, 8'h33, 8'h44 via ld_en/ld_we, drop ld_en, request addr 2 -> next cycle rsp_valid=1, rsp_instr=8'h33, rsp_addr=2, rsp_err=0.
- Back-to-back requests 0, 1, 2, 3 with rsp_ready=1 constant -> responses 11, 22, 33, 44 on 4 consecutive cycles, no bubbles.
- Request 1, hold rsp_ready=0 for 5 cycles with req_valid=1 addr 3 -> req_ready=0, rsp_instr stays 8'h22; raise rsp_ready -> 8'h44 next cycle.
- IMEM_DEPTH=10: request addr 12 -> rsp_instr=0, rsp_err=1; then request addr 9 -> rsp_err=0.
- While HOLD with rsp_ready=0 assert ld_en -> state stays HOLD, no write occurs; raise rsp_ready -> LOAD. Write mem[1]=8'hA5, exit, fetch 1 -> 8'hA5.
- Assert reset_n=0 mid-HOLD -> rsp_valid=0 in the same cycle (async). After release, fetch 0 returns 8'h11 (contents retained). With IMEM_PARITY_EN, a write with inj_par_err=1 then fetching that word -> rsp_err=1, rsp_instr=0.
